// File: rtl/rv_enc_pkg.sv
// Shared RISC-V encoding constants: opcodes, format select and the canonical NOP.
// Also holds the encoder state enum so top and bench agree on names.
package rv_enc_pkg;

    localparam logic [6:0]  OPC_I     = 7'b0010011;
    localparam logic [6:0]  OPC_S     = 7'b0100011;
    localparam logic [6:0]  OPC_SB    = 7'b1100011;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FMT_I    = 2'd0,
        FMT_S    = 2'd1,
        FMT_SB   = 2'd2,
        FMT_RSVD = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational I/S/SB field packing plus error flag; zero latency, no flow control.
// Optional INSTR_ENCODER_RANGE_CHECK_EN flags immediates that do not fit in 12 signed bits.
module instr_pack
    import rv_enc_pkg::*;
(
    input  logic [1:0]  fmt_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    fmt_e fmt;
    assign fmt = fmt_e'(fmt_i);

    // SB immediate is already in halfword units, so bit 0 of the byte offset is implicit.
    always_comb begin
        instr_o = NOP_INSTR;
        case (fmt)
            FMT_I:   instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_I};
            FMT_S:   instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_S};
            FMT_SB:  instr_o = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i,
                                imm_i[3:0], imm_i[10], OPC_SB};
            default: instr_o = NOP_INSTR;
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    logic imm_ovf;
    assign imm_ovf = !((&imm_i[31:11]) || !(|imm_i[31:11]));
    assign err_o   = (fmt == FMT_RSVD) || imm_ovf;
`else
    logic imm_hi_unused;
    assign imm_hi_unused = ^imm_i[31:12];
    assign err_o         = (fmt == FMT_RSVD);
`endif

endmodule

// File: rtl/instr_encoder.sv
// Registered instruction encoder: one output stage, word appears the cycle after accept.
// Holds output under out_ready=0; stops accepting after DEPTH words until rst.
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_fmt,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic        out_full
);

    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

    state_e        state_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_valid_q, out_err_q, out_full_q;
    logic [31:0]   out_instr_q, out_addr_q;
    logic [31:0]   pack_instr;
    logic          pack_err;
    logic          accept, drain;

    instr_pack u_pack (
        .fmt_i    (in_fmt),
        .funct3_i (in_funct3),
        .rd_i     (in_rd),
        .rs1_i    (in_rs1),
        .rs2_i    (in_rs2),
        .imm_i    (in_imm),
        .instr_o  (pack_instr),
        .err_o    (pack_err)
    );

    assign in_ready = (!out_valid_q || out_ready) && !out_full_q;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;
    assign cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= BASE_ADDR;
            out_err_q   <= 1'b0;
            out_full_q  <= 1'b0;
        end else begin
            // A simultaneous drain and accept simply reloads, keeping out_valid high.
            if (accept) begin
                out_valid_q <= 1'b1;
                out_instr_q <= pack_instr;
                out_addr_q  <= BASE_ADDR + (32'(cnt_q) << 2);
                out_err_q   <= pack_err;
                cnt_q       <= cnt_d;
            end else if (drain) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ST_EMPTY: if (accept) state_q <= ST_HOLD;
                ST_HOLD:  if (drain && !accept) state_q <= ST_EMPTY;
                default:  ;
            endcase

            if (accept && cnt_q == CNT_LAST) begin
                state_q    <= ST_FULL;
                out_full_q <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign out_full  = out_full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Table-driven bench with a scoreboard queue for the main encoder, plus a DEPTH=2 instance
// for the full and reset-in-hold sequences.
module tb_instr_encoder;

    localparam logic [31:0] MBASE = 32'hFFFF_FFF0;
    localparam logic [31:0] FBASE = 32'h0000_0100;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    typedef struct {
        logic [1:0]  fmt;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
        logic        chk_dec;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_err, out_full;
    logic [1:0]  in_fmt;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, out_instr, out_addr;
    logic        f_rst, f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_out_err, f_out_full;
    logic [31:0] f_out_instr, f_out_addr;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[10];
    int   n_vec = 0;
    int   n_bad = 0;
    int   acc_idx = 0;
    int   n_acc;

    instr_encoder #(.BASE_ADDR(MBASE), .DEPTH(64)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_funct3(in_funct3), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .out_full(out_full)
    );

    instr_encoder #(.BASE_ADDR(FBASE), .DEPTH(2)) u_full (
        .clk(clk), .rst(f_rst), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .in_fmt(in_fmt), .in_funct3(in_funct3), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(f_out_valid), .out_ready(f_out_ready),
        .out_instr(f_out_instr), .out_addr(f_out_addr), .out_err(f_out_err), .out_full(f_out_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // B-type immediate as the core's generator reconstructs it (halfword units).
    function automatic logic [31:0] imm_gen(input logic [31:0] w);
        logic [11:0] h;
        h = {w[31], w[7], w[30:25], w[11:8]};
        return {{20{h[11]}}, h};
    endfunction

    task automatic drive_fields(input vec_t v);
        in_fmt    = v.fmt;
        in_funct3 = v.f3;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_imm    = v.imm;
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input vec_t v);
        int t;
        drive_fields(v);
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            sb_q.push_back('{v.exp_instr, MBASE + 32'(acc_idx << 2), v.exp_err});
            acc_idx++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_out", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_instr", out_instr, mon_e.instr);
                check("sb_addr", out_addr, mon_e.addr);
                check("sb_err", 32'(out_err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        vecs[0] = '{2'd0, 3'd0, 5'd1,  5'd2,  5'd0,  32'd5,         32'h0051_0093, 1'b0, 1'b0};
        vecs[1] = '{2'd1, 3'd2, 5'd0,  5'd2,  5'd3,  32'd8,         32'h0031_2423, 1'b0, 1'b0};
        vecs[2] = '{2'd2, 3'd0, 5'd0,  5'd1,  5'd2,  32'hFFFF_FFFE, 32'hFE20_8EE3, 1'b0, 1'b1};
        vecs[3] = '{2'd0, 3'd0, 5'd0,  5'd0,  5'd0,  32'd2048,      32'h8000_0013, RC,   1'b0};
        vecs[4] = '{2'd3, 3'd5, 5'd9,  5'd7,  5'd6,  32'h1234_5678, 32'h0000_0013, 1'b1, 1'b0};
        vecs[5] = '{2'd0, 3'd7, 5'd31, 5'd31, 5'd0,  32'hFFFF_FFFF, 32'hFFFF_FF93, 1'b0, 1'b0};
        vecs[6] = '{2'd1, 3'd1, 5'd0,  5'd5,  5'd10, 32'hFFFF_F800, 32'h80A2_9023, 1'b0, 1'b0};
        vecs[7] = '{2'd2, 3'd1, 5'd0,  5'd3,  5'd4,  32'h0000_07FF, 32'h7E41_9FE3, 1'b0, 1'b1};
        vecs[8] = '{2'd2, 3'd0, 5'd0,  5'd0,  5'd0,  32'hFFFF_F000, 32'h0000_0063, RC,   1'b0};
        vecs[9] = '{2'd0, 3'd0, 5'd0,  5'd0,  5'd0,  32'hFFFF_F7FF, 32'h7FF0_0013, RC,   1'b0};

        rst = 1'b1; f_rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        f_in_valid = 1'b0; f_out_ready = 1'b1;
        drive_fields(vecs[0]);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; f_rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", out_addr, MBASE);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_full", 32'(out_full), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Main table; address wraps past 32'hFFFF_FFFC on the fifth word.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i]);
            @(negedge clk);
            check("out_valid_next", 32'(out_valid), 32'd1);
            if (vecs[i].chk_dec)
                check("sb_imm_gen", imm_gen(out_instr), vecs[i].imm);
            @(posedge clk);
            #1;
        end

        // Backpressure: first word held three cycles, second loads without a bubble.
        out_ready = 1'b0;
        send(vecs[5]);
        drive_fields(vecs[6]);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_instr", out_instr, 32'hFFFF_FF93);
            check("bp_hold_addr", out_addr, MBASE + 32'((acc_idx - 1) << 2));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_release", 32'(in_ready), 32'd1);
        if (in_ready) begin
            sb_q.push_back('{vecs[6].exp_instr, MBASE + 32'(acc_idx << 2), vecs[6].exp_err});
            acc_idx++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_no_bubble", 32'(out_valid), 32'd1);
        check("bp_second_addr", out_addr, MBASE + 32'((acc_idx - 1) << 2));
        @(posedge clk);
        #1;

        // DEPTH=2: third word never accepted, last word left in HOLD, then reset.
        drive_fields(vecs[1]);
        f_in_valid = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 1) check("full_not_yet", 32'(f_out_full), 32'd0);
            if (c == 2) check("full_set", 32'(f_out_full), 32'd1);
            if (f_in_valid && f_in_ready) n_acc++;
            @(posedge clk);
            #1;
            if (c == 1) f_out_ready = 1'b0;
        end
        f_in_valid = 1'b0;
        @(negedge clk);
        check("full_accepts", 32'(n_acc), 32'd2);
        check("full_in_ready", 32'(f_in_ready), 32'd0);
        check("full_sticky", 32'(f_out_full), 32'd1);
        check("full_hold_valid", 32'(f_out_valid), 32'd1);
        check("full_hold_addr", f_out_addr, FBASE + 32'd4);
        check("full_hold_instr", f_out_instr, 32'h0031_2423);
        @(posedge clk);
        #1 f_rst = 1'b1; f_out_ready = 1'b1;
        @(posedge clk);
        #1 f_rst = 1'b0; f_out_ready = 1'b0;
        @(negedge clk);
        check("hold_rst_valid", 32'(f_out_valid), 32'd0);
        check("hold_rst_addr", f_out_addr, FBASE);
        check("hold_rst_instr", f_out_instr, 32'd0);
        check("hold_rst_err", 32'(f_out_err), 32'd0);
        check("hold_rst_full", 32'(f_out_full), 32'd0);
        check("hold_rst_in_ready", 32'(f_in_ready), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("main_not_full", 32'(out_full), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
